// File: rtl/io_event_bridge.sv
`timescale 1ns/1ps
// Debounced buttons become sticky events in r20; a frame divider advances r22 and snapshots the score.
// Button edge reaches r20 after 2+DEBOUNCE_CYCLES cycles, acks act on the next edge; no backpressure.
module io_event_bridge #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAME_CYCLES    = 833333
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        btn_jump,
  input  logic        btn_duck,
  input  logic [31:0] r16,
  input  logic [31:0] r17,
  output logic [31:0] r20,
  output logic [31:0] r22,
  output logic [31:0] disp_score,
  output logic        disp_valid
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int FW = $clog2(FRAME_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FR_LAST = FW'(FRAME_CYCLES - 1);

  // Button index 0 is jump, 1 is duck.
  logic [1:0]         sync1, sync2, stable;
  logic [1:0][DW-1:0] db_cnt;
  logic [1:0]         db_flip;
  logic [1:0]         ack_hist, ack_edge;
  logic               jump_rise, tick;
  logic               jump_pend, frame_pend;
  logic [7:0]         press_cnt;
  logic [FW-1:0]      div;
  logic [31:0]        frame_q, score_q;
  logic               unused_r17;

  always_comb begin
    db_flip = '0;
    for (int i = 0; i < 2; i++) begin
      db_flip[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  assign jump_rise  = db_flip[0] & sync2[0];
  assign ack_edge   = r17[1:0] & ~ack_hist;
  assign tick       = (div == FR_LAST);
  assign unused_r17 = ^r17[31:2];

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      sync1      <= '0;
      sync2      <= '0;
      stable     <= '0;
      db_cnt     <= '0;
      ack_hist   <= '0;
      jump_pend  <= 1'b0;
      frame_pend <= 1'b0;
      press_cnt  <= '0;
      div        <= '0;
      frame_q    <= '0;
      score_q    <= '0;
      disp_valid <= 1'b0;
    end else begin
      sync1 <= {btn_duck, btn_jump};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_flip[i]) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end

      ack_hist <= r17[1:0];

      // A set on the same edge as an ack wins so no event is lost.
      if (jump_rise) begin
        jump_pend <= 1'b1;
        press_cnt <= press_cnt + 8'd1;
      end else if (ack_edge[0]) begin
        jump_pend <= 1'b0;
      end

      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        frame_q    <= frame_q + 32'd1;
        score_q    <= r16;
        frame_pend <= 1'b1;
      end else if (ack_edge[1]) begin
        frame_pend <= 1'b0;
      end
      disp_valid <= tick;
    end
  end

  assign r20        = {16'h0000, press_cnt, 5'b00000, frame_pend, stable[1], jump_pend};
  assign r22        = frame_q;
  assign disp_score = score_q;

endmodule

// File: doc/io_event_bridge.md
Name: io_event_bridge

Overview:
Input-side companion to the processor register file. It produces the values loaded into the memory-mapped input registers r20 (button/event status) and r22 (frame counter), and it consumes the processor-written registers r16 (score) and r17 (acknowledge/command). Raw push-buttons are synchronized and debounced, then captured as sticky events that software clears by handshake. A free-running frame tick paces the game loop and snapshots the score for the display.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronized button level must differ from the stable level before the stable level changes (legal range ≥2)
FRAME_CYCLES, 833333, clock cycles per frame tick (legal range ≥2)

Ports:
clock  input  1  system clock, all state on rising edge
ctrl_reset_n  input  1  asynchronous active-low reset
btn_jump  input  1  raw asynchronous jump button, active-high
btn_duck  input  1  raw asynchronous duck button, active-high
r16  input  32  processor register 16 (score)
r17  input  32  processor register 17; bit0 = jump ack, bit1 = frame ack
r20  output  32  status word to regfile input r20
r22  output  32  frame count to regfile input r22
disp_score  output  32  score snapshot for display
disp_valid  output  1  one-cycle pulse when disp_score updates

Behaviour:
- Reset, asserted asynchronously while ctrl_reset_n=0: all flops clear. r20=0, r22=0, disp_score=0, disp_valid=0, synchronizers=0, debounce counters=0, stable levels=0, frame divider=0, ack edge-detect history=0.
- Synchronizer: 2-flop chain per button. The sync output reflects a raw change 2 cycles later.
- Debounce, per button:
  - If sync != stable, the counter increments. If sync == stable, the counter clears to 0.
  - When the counter == DEBOUNCE_CYCLES-1 and sync != stable: stable <= sync and the counter clears.
  - A raw level held from cycle 0 therefore reaches stable at the edge ending cycle 2+DEBOUNCE_CYCLES-1, visible at cycle 2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES have no effect.
- Jump event:
  - jump_pending sets on the same edge that the jump stable level goes 0->1.
  - press_count, 8 bits, increments on the same edge and wraps 255->0.
- Frame divider:
  - Counts 0..FRAME_CYCLES-1 and wraps.
  - tick is asserted internally when the divider == FRAME_CYCLES-1.
  - On tick: frame_count (r22) += 1, wrapping 0xFFFFFFFF->0; frame_pending sets; disp_score <= r16.
  - disp_valid is high for exactly the cycle after tick.
- Ack handshake:
  - r17[0] and r17[1] are registered once. An ack fires on a 0->1 edge only; a held-high level does not re-clear.
  - A jump ack edge clears jump_pending. A frame ack edge clears frame_pending.
  - If set and clear occur on the same edge, set wins, so the event is not lost.
  - An ack while the flag is already clear has no effect.
- r20 layout: bit0 jump_pending, bit1 duck stable level (live, not sticky), bit2 frame_pending, bits7:3 = 0, bits15:8 press_count, bits31:16 = 0.
- r20 and r22 are driven directly from flops (no combinational path from inputs). r17/r16 changes affect outputs no earlier than the next edge.
- Mid-operation reset: all pending events, counts and the divider are discarded. After release, the first tick occurs FRAME_CYCLES cycles later.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, FRAME_CYCLES=16.)
1. Reset: hold ctrl_reset_n=0 with buttons high and r16=0x1234 -> r20=0, r22=0, disp_score=0, disp_valid=0 throughout.
2. Debounce:
   - btn_jump high for 3 cycles then low -> r20 stays 0.
   - btn_jump high for 8 cycles -> r20[0]=1 and r20[15:8]=1 at cycle 6 after the raw edge.
   - btn_duck high for 10 cycles -> r20[1]=1 while held; it returns to 0 six cycles after release.
3. Jump handshake:
   - With jump_pending=1, r17 = 0 -> 1 -> held 1 -> r20[0] clears once.
   - A second debounced press sets it again even with r17[0] still high.
   - A press whose set coincides with the ack edge leaves r20[0]=1.
4. Frame:
   - r16=0xABCD -> at tick: r22 = 1, r20[2] = 1, disp_score = 0xABCD, disp_valid high for exactly one cycle.
   - Ticks then repeat every 16 cycles. r17[1] 0->1 clears r20[2].
5. Wrap: 256 debounced jump presses -> r20[15:8] returns to 0x00. Preload via force, or run a long sim so r22=0xFFFFFFFF -> next tick gives r22 = 0.
6. Mid-operation reset: assert ctrl_reset_n low at divider=10 with both pending flags set -> immediate all-zero outputs. After release, the first disp_valid pulse arrives 17 cycles later (tick at the 16th cycle, pulse one cycle after).
